result_display_seq: RTL and testbench
=====================================

# result_display_seq

Downstream consumer of the 1 Hz square wave produced by the board clock divider. It buffers up to DEPTH result words from the RSA datapath (for example n, e, d and the ciphertext) and shows one word at a time as four hex digits on the multiplexed 7-segment display. The shown word advances on every rising edge of the slow clock, cycling through all stored words. All logic runs on the 10 MHz board clock; the slow clock is used only as a sampled level and never as a clock.

## Interface
Parameters:
- DEPTH, 4: number of word slots; power of two, at least 2.
- REFRESH_DIV, 10000: clk cycles per digit-select step (10 MHz / 10000 = 1 kHz per digit).

Ports:
- clk  in  1  10 MHz board clock.
- rst  in  1  synchronous, active-high reset.
- slow_clk  in  1  1 Hz square wave, registered in the clk domain by the divider.
- clear  in  1  one-cycle pulse; empties the buffer.
- in_data  in  16  result word to store.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  a slot is free; a write happens when in_valid and in_ready are both 1.
- cur_idx  out  log2(DEPTH)  index of the displayed word, for the LEDs.
- an  out  4  digit enables, active-low; an[0] is the rightmost digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.

## Operation
- Tick detect:
  - slow_d <= slow_clk; reset value 0.
  - tick = slow_clk & ~slow_d, a one-cycle pulse.
- Buffer:
  - Holds mem[0..DEPTH-1] and count (0..DEPTH, width log2(DEPTH)+1).
  - A write stores mem[count] <= in_data and increments count.
  - in_ready = ~rst & (count != DEPTH).
  - in_valid while the buffer is full is ignored; no overwrite.
- Two-state FSM:
  - EMPTY (count == 0): an = 4'hF, seg = 7'h7F (blank), cur_idx = 0.
  - SHOW (count ≥ 1): displays mem[cur_idx].
  - EMPTY→SHOW on the first write. SHOW→EMPTY only on clear.
- Index advance in SHOW, on tick:
  - cur_idx <= (cur_idx + 1 == count_old) ? 0 : cur_idx + 1.
  - count_old is count before any same-cycle write.
  - With count == 1 the index stays 0.
- Priority: rst > clear > (write, tick).
  - clear: count = 0, cur_idx = 0, state EMPTY, mem contents don't-care. The refresh counter keeps running.
  - A write and a tick in the same cycle both take effect.
  - A clear and an in_valid in the same cycle: the write is dropped; in_ready reads 1 in that cycle.
- Refresh:
  - rcnt counts 0..REFRESH_DIV-1 and wraps.
  - When rcnt = REFRESH_DIV-1, dsel (2 bits) increments and wraps 3→0.
  - Shown digit k = mem[cur_idx][4k+3:4k], with an[k] = 0 for k = dsel.
- Hex decode (seg, hex): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.

## Timing
- Reset values: an = 4'hF, seg = 7'h7F, cur_idx = 0, count = 0, rcnt = 0, dsel = 0, slow_d = 0, state EMPTY, in_ready = 0 while rst is high.
- an and seg are registered: they reflect the dsel, cur_idx, count and mem values of the previous cycle (1-cycle latency).
  - First write accepted at edge N: the display is non-blank from edge N+1.
- tick to cur_idx update: 1 clk cycle after slow_clk is seen high. an/seg follow one cycle later.
- in_ready drops in the cycle after the write that fills the last slot.
- rst mid-operation: all state returns to reset values at the next edge and stored words are lost.

## Test plan
Use REFRESH_DIV = 4 and DEPTH = 4.
- Reset, no writes, toggle slow_clk → an = F and seg = 7F throughout; cur_idx = 0; in_ready = 1 after rst drops.
- Write 16'h12AB, then run 16 cycles → an steps E, D, B, 7 (4 cycles each); seg steps 03, 08, 24, 79 (B, A, 2, 1); ticks leave cur_idx at 0.
- Write 1111, 2222, 3333, 4444 back-to-back → in_ready = 0 after the 4th write; a 5th write of 5555 is ignored; ticks give cur_idx 1, 2, 3, 0, and digits show 2, 3, 4, 1.
- Buffer holds 1 word; write 16'hBEEF in the same cycle as a tick → count = 2 and cur_idx stays 0; the next tick gives cur_idx = 1 and the display shows bEEF.
- With 3 words shown and cur_idx = 2, pulse clear together with in_valid → count = 0, display blank next cycle, write dropped; a subsequent write of 16'h0007 displays 0007 at cur_idx 0.
- Assert rst in the middle of a digit scan with cur_idx = 1 → next edge: an = F, seg = 7F, cur_idx = 0, count = 0.

Source files
------------

// File: rtl/result_display_seq.sv
// result_display_seq: stores up to DEPTH 16-bit result words and shows one at
// a time as four hex digits on a multiplexed, active-low 7-segment display.
// The shown word advances on each rising edge of a sampled 1 Hz level.
//
// Ports:
//   clk       board clock (all logic runs here)
//   rst       synchronous, active-high reset
//   slow_clk  1 Hz square wave, sampled as a level
//   clear     one-cycle pulse, empties the buffer
//   in_data   result word to store
//   in_valid  in_data valid this cycle
//   in_ready  a slot is free (write = in_valid & in_ready)
//   cur_idx   index of the displayed word
//   an        digit enables, active-low, an[0] rightmost
//   seg       segments {g,f,e,d,c,b,a}, active-low
module result_display_seq #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned REFRESH_DIV = 10000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       slow_clk,
    input  logic                       clear,
    input  logic [15:0]                in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [$clog2(DEPTH)-1:0]   cur_idx,
    output logic [3:0]                 an,
    output logic [6:0]                 seg
);

    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = IDX_W + 1;
    localparam int unsigned RCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REFRESH_DIV - 1);

    localparam logic [3:0] AN_BLANK  = 4'hF;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        EMPTY = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t              state;
    logic                slow_d;
    logic [CNT_W-1:0]    count;
    logic [15:0]         mem [DEPTH];
    logic [RCNT_W-1:0]   rcnt;
    logic [1:0]          dsel;

    logic                tick_c;
    logic                wr_en_c;
    logic [CNT_W-1:0]    idx_inc_c;
    logic [IDX_W-1:0]    idx_next_c;
    logic [3:0]          nib_c;
    logic [6:0]          seg_dec_c;
    logic [3:0]          an_dec_c;

    // Slot availability; forced low while in reset.
    assign in_ready = ~rst & (count != CNT_FULL);

    // A clear in the same cycle drops the write.
    assign wr_en_c = in_valid & in_ready & ~clear;

    // Rising edge of the sampled slow clock.
    assign tick_c = slow_clk & ~slow_d;

    // Next display index; wraps against the count before any same-cycle write.
    always_comb begin
        idx_inc_c  = CNT_W'(cur_idx) + CNT_W'(1);
        idx_next_c = cur_idx + IDX_W'(1);
        if (idx_inc_c == count) begin
            idx_next_c = '0;
        end
    end

    // Digit select and hex-to-segment decode for the current word.
    always_comb begin
        nib_c    = mem[cur_idx][{dsel, 2'b00} +: 4];
        an_dec_c = ~(4'b0001 << dsel);
        case (nib_c)
            4'h0:    seg_dec_c = 7'h40;
            4'h1:    seg_dec_c = 7'h79;
            4'h2:    seg_dec_c = 7'h24;
            4'h3:    seg_dec_c = 7'h30;
            4'h4:    seg_dec_c = 7'h19;
            4'h5:    seg_dec_c = 7'h12;
            4'h6:    seg_dec_c = 7'h02;
            4'h7:    seg_dec_c = 7'h78;
            4'h8:    seg_dec_c = 7'h00;
            4'h9:    seg_dec_c = 7'h10;
            4'hA:    seg_dec_c = 7'h08;
            4'hB:    seg_dec_c = 7'h03;
            4'hC:    seg_dec_c = 7'h46;
            4'hD:    seg_dec_c = 7'h21;
            4'hE:    seg_dec_c = 7'h06;
            default: seg_dec_c = 7'h0E;
        endcase
    end

    // Word storage; contents are not reset and are don't-care after clear.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[count[IDX_W-1:0]] <= in_data;
        end
    end

    // Control FSM, refresh scan and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            count   <= '0;
            cur_idx <= '0;
            slow_d  <= 1'b0;
            rcnt    <= '0;
            dsel    <= 2'd0;
            an      <= AN_BLANK;
            seg     <= SEG_BLANK;
        end else begin
            slow_d <= slow_clk;

            // Refresh keeps scanning regardless of clear.
            if (rcnt == RCNT_LAST) begin
                rcnt <= '0;
                dsel <= dsel + 2'd1;
            end else begin
                rcnt <= rcnt + RCNT_W'(1);
            end

            if (state == SHOW) begin
                an  <= an_dec_c;
                seg <= seg_dec_c;
            end else begin
                an  <= AN_BLANK;
                seg <= SEG_BLANK;
            end

            if (clear) begin
                state   <= EMPTY;
                count   <= '0;
                cur_idx <= '0;
            end else begin
                case (state)
                    EMPTY: begin
                        if (wr_en_c) begin
                            state <= SHOW;
                            count <= count + CNT_W'(1);
                        end
                    end
                    SHOW: begin
                        if (tick_c) begin
                            cur_idx <= idx_next_c;
                        end
                        if (wr_en_c) begin
                            count <= count + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= EMPTY;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_result_display_seq.sv
// Bench for result_display_seq: directed stimulus, a queue-based model of the
// word buffer and display scan, a per-cycle compare process, and literal
// expectations for the key moments of each scenario.
module tb_result_display_seq;

    localparam int DEPTH = 4;
    localparam int RDIV  = 4;

    logic        clk;
    logic        rst;
    logic        slow_clk;
    logic        clear;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  cur_idx;
    logic [3:0]  an;
    logic [6:0]  seg;

    result_display_seq #(.DEPTH(DEPTH), .REFRESH_DIV(RDIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .slow_clk (slow_clk),
        .clear    (clear),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .cur_idx  (cur_idx),
        .an       (an),
        .seg      (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit done   = 0;

    // Model state: stored words, shown index, scan position, slow-clock history.
    logic [15:0] words[$];
    int          m_idx;
    int          m_rcnt;
    int          m_dsel;
    bit          m_slow_d;
    logic [3:0]  m_an;
    logic [6:0]  m_seg;
    logic [6:0]  hex_tab [16];

    initial begin
        hex_tab[0]  = 7'h40; hex_tab[1]  = 7'h79; hex_tab[2]  = 7'h24; hex_tab[3]  = 7'h30;
        hex_tab[4]  = 7'h19; hex_tab[5]  = 7'h12; hex_tab[6]  = 7'h02; hex_tab[7]  = 7'h78;
        hex_tab[8]  = 7'h00; hex_tab[9]  = 7'h10; hex_tab[10] = 7'h08; hex_tab[11] = 7'h03;
        hex_tab[12] = 7'h46; hex_tab[13] = 7'h21; hex_tab[14] = 7'h06; hex_tab[15] = 7'h0E;
    end

    // Advance the model across one clock edge using the inputs now driven.
    task automatic model_edge();
        int old_n;
        int nib;
        bit tick;
        if (rst) begin
            words.delete();
            m_idx = 0; m_rcnt = 0; m_dsel = 0; m_slow_d = 0;
            m_an = 4'hF; m_seg = 7'h7F;
        end else begin
            if (words.size() == 0) begin
                m_an = 4'hF; m_seg = 7'h7F;
            end else begin
                nib   = int'((words[m_idx] >> (4 * m_dsel)) & 16'hF);
                m_an  = ~(4'(1 << m_dsel));
                m_seg = hex_tab[nib];
            end
            if (m_rcnt == RDIV - 1) begin
                m_rcnt = 0;
                m_dsel = (m_dsel + 1) % 4;
            end else begin
                m_rcnt++;
            end
            tick     = slow_clk && !m_slow_d;
            m_slow_d = slow_clk;
            if (clear) begin
                words.delete();
                m_idx = 0;
            end else begin
                old_n = words.size();
                if (tick && old_n > 0) m_idx = (m_idx + 1) % old_n;
                if (in_valid && old_n < DEPTH) words.push_back(in_data);
            end
        end
    endtask

    // Compare process: DUT against model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!done) begin
                checks++;
                if (an !== m_an) begin
                    errors++;
                    $display("FAIL an: got %h expected %h at %0t", an, m_an, $time);
                end
                checks++;
                if (seg !== m_seg) begin
                    errors++;
                    $display("FAIL seg: got %h expected %h at %0t", seg, m_seg, $time);
                end
                checks++;
                if (cur_idx !== 2'(m_idx)) begin
                    errors++;
                    $display("FAIL cur_idx: got %0d expected %0d at %0t", cur_idx, m_idx, $time);
                end
                checks++;
                if (in_ready !== (!rst && words.size() != DEPTH)) begin
                    errors++;
                    $display("FAIL in_ready: got %b expected %b at %0t", in_ready,
                             (!rst && words.size() != DEPTH), $time);
                end
            end
        end
    end

    task automatic check_lit(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs shortly after the falling edge.
    task automatic step(input logic r, input logic c, input logic v,
                        input logic [15:0] d, input logic s);
        @(negedge clk);
        #1;
        rst = r; clear = c; in_valid = v; in_data = d; slow_clk = s;
        model_edge();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic wr(input logic [15:0] d);
        step(1'b0, 1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic tick_pulse();
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    // Idle until the given digit is enabled, bounded.
    task automatic wait_an(input logic [3:0] target, input string name);
        bit hit = 0;
        for (int i = 0; i < 24; i++) begin
            if (an === target) begin
                hit = 1;
                break;
            end
            idle(1);
        end
        if (!hit) check_lit(name, {12'h0, an}, {12'h0, target});
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 16'h0; slow_clk = 1'b0;
        words.delete();
        m_idx = 0; m_rcnt = 0; m_dsel = 0; m_slow_d = 0;
        m_an = 4'hF; m_seg = 7'h7F;

        // Reset, then toggle slow_clk with an empty buffer.
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 1'(i % 2));
        check_lit("empty_an", {12'h0, an}, 16'h000F);
        check_lit("empty_seg", {9'h0, seg}, 16'h007F);
        check_lit("empty_idx", {14'h0, cur_idx}, 16'h0);
        check_lit("ready_after_rst", {15'h0, in_ready}, 16'h1);

        // Single word 12AB; scan all four digits, ticks keep index at 0.
        wr(16'h12AB);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 1'((i / 3) % 2));
        wait_an(4'hE, "scan_d0"); check_lit("seg_d0_B", {9'h0, seg}, 16'h0003);
        wait_an(4'hD, "scan_d1"); check_lit("seg_d1_A", {9'h0, seg}, 16'h0008);
        wait_an(4'hB, "scan_d2"); check_lit("seg_d2_2", {9'h0, seg}, 16'h0024);
        wait_an(4'h7, "scan_d3"); check_lit("seg_d3_1", {9'h0, seg}, 16'h0079);
        check_lit("one_word_idx", {14'h0, cur_idx}, 16'h0);

        // Fill the buffer; the fifth write is ignored.
        step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        wr(16'h1111); wr(16'h2222); wr(16'h3333); wr(16'h4444);
        step(1'b0, 1'b0, 1'b1, 16'h5555, 1'b0);
        check_lit("full_ready", {15'h0, in_ready}, 16'h0);
        idle(1);
        check_lit("full_ready2", {15'h0, in_ready}, 16'h0);
        tick_pulse(); check_lit("idx1", {14'h0, cur_idx}, 16'h1);
        wait_an(4'hE, "full_scan1"); check_lit("digit_2", {9'h0, seg}, 16'h0024);
        tick_pulse(); check_lit("idx2", {14'h0, cur_idx}, 16'h2);
        wait_an(4'hB, "full_scan2"); check_lit("digit_3", {9'h0, seg}, 16'h0030);
        tick_pulse(); check_lit("idx3", {14'h0, cur_idx}, 16'h3);
        wait_an(4'h7, "full_scan3"); check_lit("digit_4", {9'h0, seg}, 16'h0019);
        tick_pulse(); check_lit("idx0_wrap", {14'h0, cur_idx}, 16'h0);
        wait_an(4'hD, "full_scan0"); check_lit("digit_1", {9'h0, seg}, 16'h0079);

        // Write BEEF in the same cycle as a tick with one word held.
        step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        wr(16'hCAFE);
        step(1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b1);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        check_lit("tick_write_idx", {14'h0, cur_idx}, 16'h0);
        tick_pulse(); check_lit("beef_idx", {14'h0, cur_idx}, 16'h1);
        wait_an(4'h7, "beef_d3"); check_lit("beef_b", {9'h0, seg}, 16'h0003);
        wait_an(4'hE, "beef_d0"); check_lit("beef_F", {9'h0, seg}, 16'h000E);

        // Clear together with in_valid while showing index 2.
        step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        wr(16'hA1A1); wr(16'hB2B2); wr(16'hC3C3);
        tick_pulse(); tick_pulse();
        check_lit("pre_clear_idx", {14'h0, cur_idx}, 16'h2);
        step(1'b0, 1'b1, 1'b1, 16'h9999, 1'b0);
        check_lit("clear_ready", {15'h0, in_ready}, 16'h1);
        idle(2);
        check_lit("clear_an", {12'h0, an}, 16'h000F);
        check_lit("clear_seg", {9'h0, seg}, 16'h007F);
        check_lit("clear_idx", {14'h0, cur_idx}, 16'h0);
        wr(16'h0007);
        wait_an(4'hE, "w7_d0"); check_lit("w7_seg7", {9'h0, seg}, 16'h0078);
        wait_an(4'hD, "w7_d1"); check_lit("w7_seg0", {9'h0, seg}, 16'h0040);

        // Reset mid-scan with cur_idx = 1.
        wr(16'h0008);
        tick_pulse();
        check_lit("pre_rst_idx", {14'h0, cur_idx}, 16'h1);
        idle(1);
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        check_lit("rst_an", {12'h0, an}, 16'h000F);
        check_lit("rst_seg", {9'h0, seg}, 16'h007F);
        check_lit("rst_idx", {14'h0, cur_idx}, 16'h0);
        check_lit("rst_ready", {15'h0, in_ready}, 16'h0);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        idle(3);
        check_lit("post_rst_ready", {15'h0, in_ready}, 16'h1);
        check_lit("post_rst_an", {12'h0, an}, 16'h000F);

        done = 1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
